// File: rtl/y_alu_if.sv
// Operand/result bundle for y_alu: the driver owns a, b and op, the ALU
// owns the registered result z and its zero flag.
interface y_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [WIDTH-1:0] z;
  logic             zero;

  modport master (output a, b, op, input  z, zero);
  modport slave  (input  a, b, op, output z, zero);
endinterface

// File: rtl/y_alu.sv
// Single-cycle registered ALU: AND, OR, ADD, SUB and unsigned SLT.
// ADD, SUB and SLT share one adder; op[2] selects the inverted b operand
// and the carry-in, so SUB is a + ~b + 1 and SLT reads that adder's
// carry-out. The result and its zero flag load on the same edge.
module y_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  y_alu_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             carry_out;
  logic [WIDTH-1:0] z_d, z_q;
  logic             zero_d, zero_q;

  // Shared adder: op[2] inverts b and injects the +1 for two's complement.
  always_comb begin
    b_eff     = bus.op[2] ? ~bus.b : bus.b;
    sum_full  = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op[2]};
    carry_out = sum_full[WIDTH];
  end

  // Result select; unused opcodes fall through to zero.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
    z_d = '0;
    unique case (bus.op)
      OP_AND:  z_d = bus.a & bus.b;
      OP_OR:   z_d = bus.a | bus.b;
      OP_ADD,
      OP_SUB:  z_d = sum_full[WIDTH-1:0];
      // No carry out of a + ~b + 1 means a borrow occurred, i.e. a < b unsigned.
      OP_SLT:  z_d = {{(WIDTH-1){1'b0}}, ~carry_out};
      default: z_d = '0;
    endcase
    // Derived from the value being loaded so z and zero never disagree.
    zero_d = ~|z_d;
  end

  // Output register with asynchronous reset to z = 0, zero = 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q    <= '0;
      zero_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      z_q    <= z_d;
      zero_q <= zero_d;
    end
  end

  assign bus.z    = z_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_y_alu.sv
// Self-checking bench for y_alu: directed vectors, illegal opcodes,
// randomized stream against an arithmetic reference model, and
// asynchronous reset in mid-stream.
module tb_y_alu;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  y_alu_if #(.WIDTH(W)) bus ();

  y_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the operation table.
  function automatic logic [W-1:0] model_z(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Drive one operation at the falling edge, then step past the next rising edge.
  task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(3'b001, 32'h0000_0001, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checks++;
    if (bus.z !== 32'hF000_F000 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_and: z=%h zero=%b, expected z=f000f000 zero=0", bus.z, bus.zero);
    end
  endtask

  task automatic test_or_add();
    apply(3'b001, 32'h1234_0000, 32'h0000_5678);
    checks++;
    if (bus.z !== 32'h1234_5678 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL or: z=%h zero=%b, expected z=12345678 zero=0", bus.z, bus.zero);
    end
    apply(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    apply(3'b010, 32'h0000_1234, 32'h0000_4321);
    checks++;
    if (bus.z !== 32'h0000_5555 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL add: z=%h zero=%b, expected z=00005555 zero=0", bus.z, bus.zero);
    end
  endtask

  task automatic test_sub();
    apply(3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_equal: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    apply(3'b110, 32'd5, 32'd7);
    checks++;
    if (bus.z !== 32'hFFFF_FFFE || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: z=%h zero=%b, expected z=fffffffe zero=0", bus.z, bus.zero);
    end
  endtask

  task automatic test_slt();
    apply(3'b111, 32'd3, 32'h8000_0000);
    checks++;
    if (bus.z !== 32'h1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_less: z=%h zero=%b, expected z=00000001 zero=0", bus.z, bus.zero);
    end
    apply(3'b111, 32'h8000_0000, 32'd3);
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_greater: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    apply(3'b111, 32'h1357_9BDF, 32'h1357_9BDF);
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_equal: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad_ops [3] = '{3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 3; i++) begin
      // Load a nonzero result first so the illegal op must actively clear it.
      apply(3'b001, 32'hA5A5_0000, 32'h0000_5A5A);
      apply(bad_ops[i], 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      checks++;
      if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
        errors++;
        $display("FAIL illegal_op%b: z=%h zero=%b, expected z=00000000 zero=1",
                 bad_ops[i], bus.z, bus.zero);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]   ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    logic [2:0]   op;
    logic [W-1:0] a, b, exp_z;
    int           n_err = 0;
    for (int i = 0; i < 1000; i++) begin
      op = ops[$urandom_range(0, 4)];
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? a : W'($urandom);
      apply(op, a, b);
      exp_z = model_z(op, a, b);
      checks++;
      if (bus.z !== exp_z || bus.zero !== (exp_z == 0)) begin
        errors++;
        n_err++;
        if (n_err <= 10)
          $display("FAIL random[%0d] op=%b a=%h b=%h: z=%h zero=%b, expected z=%h zero=%b",
                   i, op, a, b, bus.z, bus.zero, exp_z, (exp_z == 0));
      end
    end
  endtask

  task automatic test_hold_between_edges();
    apply(3'b001, 32'h0F00_0000, 32'h0000_00F0);
    // Changing inputs mid-cycle must not disturb the registered result.
    bus.op = 3'b000;
    bus.a  = 32'h0;
    bus.b  = 32'h0;
    #3;
    checks++;
    if (bus.z !== 32'h0F00_00F0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_between_edges: z=%h zero=%b, expected z=0f0000f0 zero=0", bus.z, bus.zero);
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0]   op;
    logic [W-1:0] a, b, exp_z;
    for (int i = 0; i < 4; i++) begin
      apply(3'b010, W'($urandom) | 32'h1, 32'h0);
    end
    // Now #1 after a rising edge: load a new op, then pulse reset before the next edge.
    op = 3'b110;
    a  = 32'h0000_0100;
    b  = 32'h0000_0001;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.z !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL after_release_hold: z=%h zero=%b, expected z=00000000 zero=1", bus.z, bus.zero);
    end
    @(posedge clk);
    #1;
    exp_z = model_z(op, a, b);
    checks++;
    if (bus.z !== exp_z || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL resume_after_reset: z=%h zero=%b, expected z=%h zero=0", bus.z, bus.zero, exp_z);
    end
    apply(3'b111, 32'd1, 32'd2);
    checks++;
    if (bus.z !== 32'h1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL resume_stream: z=%h zero=%b, expected z=00000001 zero=0", bus.z, bus.zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.op = 3'b000;
    bus.a  = '0;
    bus.b  = '0;
    #12;
    rst = 1'b0;

    test_reset();
    test_or_add();
    test_sub();
    test_slt();
    test_illegal();
    test_hold_between_edges();
    test_random();
    test_midstream_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y_alu.md
Y_ALU -- requirements
Module: y_alu

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, data path width in bits; all requirements below assume WIDTH=32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port z, output, WIDTH bits: registered ALU result.
REQ-005 The module SHALL have port zero, output, 1 bit: registered flag, 1 when z equals all zeros.
REQ-006 The module SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 The module SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 The module SHALL have port op, input, 3 bits: operation select.

Function
REQ-009 The module SHALL decode op as follows:
- 3'b000: AND, z = a & b.
- 3'b001: OR, z = a | b.
- 3'b010: ADD, z = a + b.
- 3'b110: SUB, z = a - b.
- 3'b111: SLT, z = 1 if a < b else 0.
REQ-010 ADD and SUB SHALL be modulo 2^WIDTH; the carry-out and overflow SHALL be discarded, with no extra outputs.
REQ-011 SUB SHALL be computed as a + ~b + 1 through the same adder used for ADD; op[2] acts as the b-invert and carry-in control.
REQ-012 SLT SHALL be an unsigned comparison: z[0] = NOT carry-out of a + ~b + 1, and z[WIDTH-1:1] = 0.
REQ-013 The unused opcodes 3'b011, 3'b100 and 3'b101 SHALL produce z = 0 and zero = 1.
REQ-014 The result SHALL be computed combinationally from a, b and op, then registered into z on each rising clk edge.
- Latency: exactly 1 cycle.
- Throughput: one operation per cycle.
- No handshake; a new operation is accepted every cycle.
REQ-015 zero SHALL be registered on the same edge as z and SHALL equal the reduction-NOR of the value being loaded into z, so zero and z are never out of step.
REQ-016 Changes on a, b or op between clock edges SHALL NOT affect z or zero until the next rising edge.
REQ-017 Boundary results:
- a == b under SUB: z = 0, zero = 1.
- a == b under SLT: z = 0.
- a = 0xFFFFFFFF, b = 1 under ADD: z = 0, zero = 1.

Reset
REQ-018 While rst = 1, z SHALL be 0 and zero SHALL be 1, immediately and independent of clk.
REQ-019 After rst deasserts, the first rising clk edge SHALL load the result of the op, a and b present at that edge.
REQ-020 Asserting rst in mid-operation SHALL discard the pending result, with no residual state.

Verification
REQ-021 Reset: assert rst with no clock edge -> z = 0x00000000, zero = 1; deassert, then apply op=000, a=0xF0F0F0F0, b=0xFF00FF00 and clock once -> z = 0xF000F000, zero = 0.
REQ-022 OR and ADD:
- op=001, a=0x12340000, b=0x00005678 -> z = 0x12345678 one cycle later.
- op=010, a=0xFFFFFFFF, b=0x00000001 -> z = 0, zero = 1 (carry discarded).
REQ-023 SUB:
- op=110, a=b=0xDEADBEEF -> z = 0, zero = 1.
- op=110, a=5, b=7 -> z = 0xFFFFFFFE, zero = 0.
REQ-024 SLT, unsigned:
- op=111, a=3, b=0x80000000 -> z = 1.
- op=111, a=0x80000000, b=3 -> z = 0.
- op=111, a=b -> z = 0, zero = 1.
REQ-025 Randomized: 1000 cycles of random a and b, with b forced equal to a on about 50% of cycles, across all five legal ops; each z and zero SHALL match a software model delayed by one cycle, including the zero = 1 cases when a == b.
REQ-026 Illegal op and mid-stream reset:
- op=100 with nonzero a and b -> z = 0, zero = 1.
- rst pulsed between edges during a stream -> z = 0 immediately, and the stream resumes correctly on the next edge after release.
